rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 32x32 integer register file between two writeback sources: ALU/execute result (ALU) and load data from memory (MEM).
- Each source has a one-entry holding slot with a valid/ready handshake. A round-robin arbiter drains the slots into a registered write port.
- Drives Write_En / Add_Dest / Write_Data of the register file.
- Exports a pending-write mask used by hazard logic, and a contention counter.

Parameters:
- XLEN, 32, data width of a register write.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU slot can accept this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  MEM writeback request.
- mem_ready  out  1  MEM slot can accept this cycle.
- mem_rd  in  5  MEM destination register.
- mem_data  in  XLEN  load result.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file destination address (registered).
- rf_wdata  out  XLEN  register-file write data (registered).
- busy_mask  out  32  bit r = 1 while a write to xr is held in a slot or on the output stage.
- conflict_cnt  out  CNT_W  number of cycles in which both slots were valid.

Behaviour:
Reset
- While RST=1 at a rising edge:
  - both slots are cleared to invalid;
  - rf_we=0, rf_rd=0, rf_wdata=0;
  - last_grant is set to MEM, so ALU wins the first contest;
  - the age bit is set to MEM-older;
  - conflict_cnt=0.
- alu_ready and mem_ready are forced to 0 while RST=1. Handshakes in that cycle are ignored.
- Reset mid-operation discards all held entries without writing them.

Handshake
- A transfer occurs when valid && ready at a rising edge.
- ready_x = !slot_x.valid || grant_x. Ready does not depend on valid_x, so there is no combinational valid-to-ready path.
- A requester may present a new entry in the same cycle its held entry is granted, giving back-to-back throughput.
- Entries with rd==0 are accepted and discarded at the handshake. The slot is not loaded and no write is ever issued to x0.

Arbitration (combinational, from slot state only)
- Only one slot valid: that slot is granted.
- Both slots valid and rd differs: grant the source != last_grant.
- Both slots valid and rd equal: grant the older entry (age bit), overriding round-robin.
- Age bit update:
  - ALU captured while MEM slot is valid: MEM-older.
  - MEM captured while ALU slot is valid: ALU-older.
  - Both captured at the same edge: MEM-older.
- last_grant is updated on every grant.

Output stage and latency
- At each edge:
  - rf_we <= any grant;
  - rf_rd and rf_wdata <= the granted slot's contents;
  - the granted slot is freed, or reloaded if a new handshake occurs.
- Uncontested latency:
  - handshake at edge E0;
  - slot is granted in the cycle after E0;
  - rf_* are valid after edge E1;
  - the register file captures the write at E2.
- A contested loser waits exactly one extra cycle. Round-robin bounds the wait to 1 grant.

busy_mask
- busy_mask = OR of onehot(slot_alu.rd) if valid, onehot(slot_mem.rd) if valid, and onehot(rf_rd) if rf_we.
- Bit 0 is always 0.
- Derived purely from registers (no input dependence).

conflict_cnt
- Increments at each edge where both slots are valid (and RST=0).
- Saturates at 2^CNT_W-1 and does not wrap.

Decomposition:
- Package rv32_rf_pkg:
  - XLEN_DEF=32;
  - REG_ADDR_W=5;
  - NUM_REGS=32;
  - enum wb_src_t {SRC_ALU=1'b0, SRC_MEM=1'b1}.
- Sub-module wb_slot: one-entry valid/rd/data holding register with load, free, and ready generation. It is instantiated twice.
- The arbiter, age logic, output stage, busy_mask and counter stay in rf_wb_arbiter.

Test Plan:
1. Reset then single ALU write:
   - stimulus: alu_valid=1, rd=5, data=0x0000_00AA for one cycle;
   - response: rf_we=1 with rf_rd=5 and rf_wdata=0xAA exactly one cycle after the handshake edge;
   - busy_mask[5]=1 for 2 cycles, then 0.
2. Simultaneous requests, different rd:
   - stimulus: ALU rd=3 data=0x11 and MEM rd=4 data=0x22 at the same edge;
   - response: rd 3 is written first, then rd 4 on the next cycle;
   - conflict_cnt=1.
3. Simultaneous requests, same rd:
   - stimulus: ALU rd=7 data=0x1 and MEM rd=7 data=0x2 at the same edge;
   - response: MEM (0x2) is written first, then ALU (0x1);
   - the final register value is 0x1.
4. Sustained contention:
   - stimulus: both sources hold valid with distinct rd for 8 cycles;
   - response: grants alternate ALU, MEM, ALU, …;
   - each ready toggles every other cycle;
   - 8 writes complete in 8 cycles.
5. x0 and saturation:
   - stimulus: ALU rd=0 data=0xFFFF_FFFF;
   - response: accepted, rf_we stays 0, busy_mask stays 0;
   - stimulus: CNT_W=2 with 5 contended cycles;
   - response: conflict_cnt=3.
6. Reset mid-operation:
   - stimulus: both slots loaded, then RST=1 for 1 cycle;
   - response: no write is issued;
   - rf_we=0, busy_mask=0, conflict_cnt=0, and readys are 0 during RST.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rv32_rf_pkg : shared types and constants for the register-file writeback path
// Rev 1.0
// ============================================================================
package rv32_rf_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd,
                                                    input logic                  en);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (en) v[rd] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter_if : writeback request channels and register-file write port
// Rev 1.0
// ============================================================================
interface rf_wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  import rv32_rf_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_wdata;
  logic [NUM_REGS-1:0]   busy_mask;
  logic [CNT_W-1:0]      conflict_cnt;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rf_we, rf_rd, rf_wdata, busy_mask, conflict_cnt
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, rf_we, rf_rd, rf_wdata, busy_mask, conflict_cnt
  );

endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter_wb_slot.sv
`default_nettype none
// ============================================================================
// wb_slot : one-entry writeback holding register with valid/ready handshake
// Rev 1.0
// ============================================================================
module wb_slot
  import rv32_rf_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic                  CLK,
  input  wire logic                  RST,
  input  wire logic                  i_valid,
  input  wire logic [REG_ADDR_W-1:0] i_rd,
  input  wire logic [XLEN-1:0]       i_data,
  input  wire logic                  i_grant,
  output logic                       o_ready,
  output logic                       o_load,
  output logic                       o_valid,
  output logic [REG_ADDR_W-1:0]      o_rd,
  output logic [XLEN-1:0]            o_data
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;

  // Ready looks only at slot state and the grant, never at i_valid.
  assign o_ready = !RST && (!r_valid || i_grant);
  // Writes to x0 complete the handshake but are dropped here.
  assign o_load  = i_valid && o_ready && (i_rd != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (o_load) begin
      r_valid <= 1'b1;
      r_rd    <= i_rd;
      r_data  <= i_data;
    end else if (i_grant) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_rd    = r_rd;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter : round-robin/age arbiter sharing the RF write port (ALU, MEM)
// Rev 1.0
// ============================================================================
module rf_wb_arbiter
  import rv32_rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  rf_wb_arbiter_if.slave   bus
);

  logic                  w_a_v, w_m_v, w_a_load, w_m_load;
  logic [REG_ADDR_W-1:0] w_a_rd, w_m_rd;
  logic [XLEN-1:0]       w_a_data, w_m_data;
  logic                  w_gnt_alu, w_gnt_mem;
  logic [NUM_REGS-1:0]   w_busy;

  wb_src_t               r_last_grant;
  wb_src_t               r_older;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_wdata;
  logic [CNT_W-1:0]      r_cnt;

  wb_slot #(.XLEN(XLEN)) u_slot_alu (
    .CLK    (CLK),
    .RST    (RST),
    .i_valid(bus.alu_valid),
    .i_rd   (bus.alu_rd),
    .i_data (bus.alu_data),
    .i_grant(w_gnt_alu),
    .o_ready(bus.alu_ready),
    .o_load (w_a_load),
    .o_valid(w_a_v),
    .o_rd   (w_a_rd),
    .o_data (w_a_data)
  );

  wb_slot #(.XLEN(XLEN)) u_slot_mem (
    .CLK    (CLK),
    .RST    (RST),
    .i_valid(bus.mem_valid),
    .i_rd   (bus.mem_rd),
    .i_data (bus.mem_data),
    .i_grant(w_gnt_mem),
    .o_ready(bus.mem_ready),
    .o_load (w_m_load),
    .o_valid(w_m_v),
    .o_rd   (w_m_rd),
    .o_data (w_m_data)
  );

  // Same-rd contests go to the older entry so the later write lands last.
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_mem = 1'b0;
    if (w_a_v && w_m_v) begin
      if (w_a_rd == w_m_rd) begin
        w_gnt_alu = (r_older == SRC_ALU);
      end else begin
        w_gnt_alu = (r_last_grant == SRC_MEM);
      end
      w_gnt_mem = !w_gnt_alu;
    end else begin
      w_gnt_alu = w_a_v;
      w_gnt_mem = w_m_v;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_grant <= SRC_MEM;
      r_older      <= SRC_MEM;
      r_we         <= 1'b0;
      r_rd         <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
    end else begin
      r_we <= w_gnt_alu || w_gnt_mem;
      if (w_gnt_alu) begin
        r_rd         <= w_a_rd;
        r_wdata      <= w_a_data;
        r_last_grant <= SRC_ALU;
      end else if (w_gnt_mem) begin
        r_rd         <= w_m_rd;
        r_wdata      <= w_m_data;
        r_last_grant <= SRC_MEM;
      end
      if (w_a_load) begin
        r_older <= SRC_MEM;
      end else if (w_m_load) begin
        r_older <= SRC_ALU;
      end
      if (w_a_v && w_m_v && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_busy = rd_onehot(w_a_rd, w_a_v) | rd_onehot(w_m_rd, w_m_v) | rd_onehot(r_rd, r_we);

  assign bus.rf_we        = r_we;
  assign bus.rf_rd        = r_rd;
  assign bus.rf_wdata     = r_wdata;
  assign bus.busy_mask    = {w_busy[NUM_REGS-1:1], 1'b0};
  assign bus.conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_arbiter : directed and random checks against a behavioural model
// Rev 1.0
// ============================================================================
module tb_rf_wb_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rf_wb_arbiter_if #(.XLEN(32), .CNT_W(16)) ifm ();
  rf_wb_arbiter_if #(.XLEN(32), .CNT_W(2))  ifs ();

  assign ifs.alu_valid = ifm.alu_valid;
  assign ifs.alu_rd    = ifm.alu_rd;
  assign ifs.alu_data  = ifm.alu_data;
  assign ifs.mem_valid = ifm.mem_valid;
  assign ifs.mem_rd    = ifm.mem_rd;
  assign ifs.mem_data  = ifm.mem_data;

  rf_wb_arbiter #(.XLEN(32), .CNT_W(16)) dut   (.CLK(CLK), .RST(RST), .bus(ifm));
  rf_wb_arbiter #(.XLEN(32), .CNT_W(2))  dut_s (.CLK(CLK), .RST(RST), .bus(ifs));

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Model state: index 0 = ALU source, 1 = MEM source
  ent_t        ms[2];
  int          m_last, m_older, m_cnt;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  bit          m_acc[2];
  logic [31:0] d_regs[32];

  int n_pass = 0, n_tot = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    ifm.alu_valid = av; ifm.alu_rd = ard; ifm.alu_data = ad;
    ifm.mem_valid = mv; ifm.mem_rd = mrd; ifm.mem_data = md;
  endtask

  task automatic model_reset();
    ms[0] = '0; ms[1] = '0;
    m_last = 1; m_older = 1; m_cnt = 0;
    m_we = 0; m_rd = '0; m_wd = '0;
  endtask

  // One clock: check readys, advance the model across the edge, check outputs.
  task automatic tick();
    int          win;
    bit          rdy[2], ld[2], rst_now;
    ent_t        in_e[2];
    logic [31:0] bm;
    #1;
    rst_now = RST;
    in_e[0] = '{ifm.alu_valid, ifm.alu_rd, ifm.alu_data};
    in_e[1] = '{ifm.mem_valid, ifm.mem_rd, ifm.mem_data};
    win = -1;
    if (ms[0].v && ms[1].v) win = (ms[0].rd == ms[1].rd) ? m_older : 1 - m_last;
    else if (ms[0].v)       win = 0;
    else if (ms[1].v)       win = 1;
    for (int s = 0; s < 2; s++) rdy[s] = !rst_now && (!ms[s].v || win == s);
    check("alu_ready", ifm.alu_ready, rdy[0]);
    check("mem_ready", ifm.mem_ready, rdy[1]);
    @(posedge CLK);
    if (rst_now) begin
      model_reset();
      m_acc[0] = 0; m_acc[1] = 0;
    end else begin
      if (ms[0].v && ms[1].v) m_cnt++;
      m_we = (win >= 0);
      if (win >= 0) begin
        m_rd = ms[win].rd; m_wd = ms[win].data;
        m_last = win; ms[win].v = 0;
      end
      for (int s = 0; s < 2; s++) begin
        m_acc[s] = in_e[s].v && rdy[s];
        ld[s]    = m_acc[s] && (in_e[s].rd != 0);
        if (ld[s]) ms[s] = in_e[s];
      end
      if (ld[0]) m_older = 1;
      else if (ld[1]) m_older = 0;
    end
    #1;
    if (ifm.rf_we === 1'b1) d_regs[ifm.rf_rd] = ifm.rf_wdata;
    bm = '0;
    for (int s = 0; s < 2; s++) if (ms[s].v) bm[ms[s].rd] = 1'b1;
    if (m_we) bm[m_rd] = 1'b1;
    bm[0] = 1'b0;
    check("rf_we", ifm.rf_we, m_we);
    if (m_we) begin
      check("rf_rd", ifm.rf_rd, m_rd);
      check("rf_wdata", ifm.rf_wdata, m_wd);
    end
    check("busy_mask", ifm.busy_mask, bm);
    check("conflict_cnt", ifm.conflict_cnt, m_cnt);
    check("conflict_cnt_sat", ifs.conflict_cnt, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    RST = 1'b0;
  endtask

  // Both sources keep requesting with distinct rd; new payload after each accept.
  task automatic sustain(input int n, output int writes, output int alu_writes);
    logic [4:0]  ard = 5'd8, mrd = 5'd16;
    logic [31:0] ad = 32'h100, md = 32'h200;
    writes = 0; alu_writes = 0;
    for (int i = 0; i < n; i++) begin
      set_in(1, ard, ad, 1, mrd, md);
      tick();
      if (m_acc[0]) begin ard = 5'd8 + 5'((ard + 1) % 4); ad++; end
      if (m_acc[1]) begin mrd = 5'd16 + 5'((mrd + 1) % 4); md++; end
      if (i >= 1 && i <= 8 && ifm.rf_we === 1'b1) begin
        writes++;
        if (ifm.rf_rd < 16) alu_writes++;
      end
    end
  endtask

  initial begin
    int w, aw, guard;
    for (int r = 0; r < 32; r++) d_regs[r] = '0;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0);

    do_reset();
    do_reset();
    check("reset_rf_rd", ifm.rf_rd, 0);
    check("reset_rf_wdata", ifm.rf_wdata, 0);

    // Single uncontested ALU write
    set_in(1, 5'd5, 32'hAA, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    check("t1_busy5_e0", ifm.busy_mask[5], 1);
    check("t1_we_e0", ifm.rf_we, 0);
    tick();
    check("t1_we_e1", ifm.rf_we, 1);
    check("t1_rd_e1", ifm.rf_rd, 5);
    check("t1_data_e1", ifm.rf_wdata, 32'hAA);
    check("t1_busy5_e1", ifm.busy_mask[5], 1);
    tick();
    check("t1_busy5_e2", ifm.busy_mask[5], 0);

    // Simultaneous, different rd: ALU wins first contest after reset
    do_reset();
    set_in(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    check("t2_first_rd", ifm.rf_rd, 3);
    check("t2_first_data", ifm.rf_wdata, 32'h11);
    check("t2_conflicts", ifm.conflict_cnt, 1);
    tick();
    check("t2_second_rd", ifm.rf_rd, 4);
    check("t2_second_data", ifm.rf_wdata, 32'h22);
    tick();

    // Simultaneous, same rd: MEM is older, ALU value survives
    do_reset();
    set_in(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    check("t3_first_data", ifm.rf_wdata, 32'h2);
    tick();
    check("t3_second_data", ifm.rf_wdata, 32'h1);
    tick();
    check("t3_final_x7", d_regs[7], 32'h1);

    // Sustained contention
    do_reset();
    sustain(9, w, aw);
    check("t4_writes", w, 8);
    check("t4_alu_writes", aw, 4);
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // x0 discard, then counter saturation on the narrow instance
    do_reset();
    set_in(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
    tick();
    check("t5_x0_accepted", m_acc[0], 1);
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) begin
      tick();
      check("t5_x0_no_we", ifm.rf_we, 0);
      check("t5_x0_busy", ifm.busy_mask, 0);
    end
    do_reset();
    guard = 0;
    while (m_cnt < 5 && guard < 20) begin
      sustain(1, w, aw);
      guard++;
    end
    check("t5_sat_cnt", ifs.conflict_cnt, 3);
    check("t5_full_cnt", ifm.conflict_cnt, 5);

    // Reset while both slots hold entries
    do_reset();
    set_in(1, 5'd9, 32'h99, 1, 5'd10, 32'hAB);
    tick();
    RST = 1'b1;
    tick();
    check("t6_we", ifm.rf_we, 0);
    check("t6_busy", ifm.busy_mask, 0);
    check("t6_cnt", ifm.conflict_cnt, 0);
    RST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    check("t6_no_write", ifm.rf_we, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      if (i % 97 == 96) RST = 1'b1;
      tick();
      RST = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
